// File: rtl/game_control_multi_if.sv
// Key, switch and datapath signals between the debounced front end and the game sequencer.
// The pause input exists only when GAME_CTRL_PAUSE_EN is defined.
interface game_control_multi_if #(
   parameter int TGT_W  = 7,
   parameter int SHOT_W = 3
);
   logic              start;
   logic              load_target;
   logic              load_angle;
   logic              load_strength;
   logic [TGT_W-1:0]  counter_square;
   logic              win;
   logic              lose;
`ifdef GAME_CTRL_PAUSE_EN
   logic              pause;
`endif
   logic              datapath_reset;
   logic              datapath_start;
   logic              datapath_target;
   logic              datapath_load_angle;
   logic              datapath_load_strength;
   logic              datapath_draw;
   logic              datapath_hit;
   logic              datapath_miss;
   logic              datapath_win;
   logic              datapath_lose;
   logic [SHOT_W-1:0] shots_left;
   logic [SHOT_W-1:0] score;

   modport slave (
`ifdef GAME_CTRL_PAUSE_EN
      input  pause,
`endif
      input  start, load_target, load_angle, load_strength, counter_square, win, lose,
      output datapath_reset, datapath_start, datapath_target, datapath_load_angle,
             datapath_load_strength, datapath_draw, datapath_hit, datapath_miss,
             datapath_win, datapath_lose, shots_left, score
   );

   modport master (
`ifdef GAME_CTRL_PAUSE_EN
      output pause,
`endif
      output start, load_target, load_angle, load_strength, counter_square, win, lose,
      input  datapath_reset, datapath_start, datapath_target, datapath_load_angle,
             datapath_load_strength, datapath_draw, datapath_hit, datapath_miss,
             datapath_win, datapath_lose, shots_left, score
   );
endinterface

// File: rtl/game_control_multi.sv
// Multi-shot projectile game sequencer: shot budget, hit score, flight timeout, Moore strobes.
// Define GAME_CTRL_PAUSE_EN to add a pause input that freezes the shot phases.
module game_control_multi #(
   parameter int TGT_W        = 7,
   parameter int TGT_DONE     = 64,
   parameter int SHOT_W       = 3,
   parameter int SHOTS        = 3,
   parameter int HITS_TO_WIN  = 2,
   parameter int TO_W         = 20,
   parameter int DRAW_TIMEOUT = 1000000
) (
   input logic                 clk,
   input logic                 reset,
   game_control_multi_if.slave io_bus
);
   localparam logic [3:0] S_RESET  = 4'd0;
   localparam logic [3:0] S_START  = 4'd1;
   localparam logic [3:0] S_TARGET = 4'd2;
   localparam logic [3:0] S_WAIT_A = 4'd3;
   localparam logic [3:0] S_LOAD_A = 4'd4;
   localparam logic [3:0] S_WAIT_S = 4'd5;
   localparam logic [3:0] S_LOAD_S = 4'd6;
   localparam logic [3:0] S_DRAW   = 4'd7;
   localparam logic [3:0] S_HIT    = 4'd8;
   localparam logic [3:0] S_MISS   = 4'd9;
   localparam logic [3:0] S_WIN    = 4'd10;
   localparam logic [3:0] S_LOSE   = 4'd11;

   localparam logic [TGT_W-1:0]  TGT_DONE_V = TGT_W'(TGT_DONE);
   localparam logic [SHOT_W-1:0] SHOTS_V    = SHOT_W'(SHOTS);
   localparam logic [SHOT_W-1:0] HITS_V     = SHOT_W'(HITS_TO_WIN);
   localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(DRAW_TIMEOUT - 1);

   logic [3:0]        r_state;
   logic [SHOT_W-1:0] r_shots_left;
   logic [SHOT_W-1:0] r_score;
   logic [TO_W-1:0]   r_timeout;

   logic [3:0]        w_state_next;
   logic              w_hold;
   logic              w_expired;
   logic [9:0]        w_strobe;

   assign w_expired = (r_timeout == TO_LAST);

   always_comb begin
      w_hold = 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
      w_hold = io_bus.pause && (r_state inside {S_WAIT_A, S_LOAD_A, S_WAIT_S, S_LOAD_S, S_DRAW});
`endif
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_RESET:  if (io_bus.start)                   w_state_next = S_START;
         S_START:  if (io_bus.load_target)             w_state_next = S_TARGET;
         S_TARGET: if (io_bus.counter_square == TGT_DONE_V) w_state_next = S_WAIT_A;
         S_WAIT_A: if (io_bus.load_angle)              w_state_next = S_LOAD_A;
         S_LOAD_A: if (!io_bus.load_angle)             w_state_next = S_WAIT_S;
         S_WAIT_S: if (io_bus.load_strength)           w_state_next = S_LOAD_S;
         S_LOAD_S: if (!io_bus.load_strength)          w_state_next = S_DRAW;
         // win outranks lose, which outranks the timeout
         S_DRAW: begin
            if (io_bus.win)       w_state_next = S_HIT;
            else if (io_bus.lose) w_state_next = S_MISS;
            else if (w_expired)   w_state_next = S_MISS;
         end
         S_HIT: begin
            if (r_score == HITS_V)         w_state_next = S_WIN;
            else if (r_shots_left == '0)   w_state_next = S_LOSE;
            else                           w_state_next = S_WAIT_A;
         end
         S_MISS:   w_state_next = (r_shots_left == '0) ? S_LOSE : S_WAIT_A;
         S_WIN, S_LOSE: if (io_bus.start)              w_state_next = S_START;
         default:  w_state_next = S_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_RESET;
         r_shots_left <= SHOTS_V;
         r_score      <= '0;
         r_timeout    <= '0;
      end else if (!w_hold) begin
         r_state <= w_state_next;
         if (w_state_next == S_START && r_state != S_START) begin
            r_shots_left <= SHOTS_V;
            r_score      <= '0;
         end else if (r_state == S_LOAD_S && w_state_next == S_DRAW && r_shots_left != '0) begin
            r_shots_left <= r_shots_left - SHOT_W'(1);
         end else if (r_state == S_DRAW && w_state_next == S_HIT && r_score < HITS_V) begin
            r_score <= r_score + SHOT_W'(1);
         end
         // Non-DRAW cycles keep the counter cleared so each flight starts from zero
         if (r_state == S_DRAW) r_timeout <= r_timeout + TO_W'(1);
         else                   r_timeout <= '0;
      end
   end

   always_comb begin
      w_strobe = '0;
      case (r_state)
         S_RESET:  w_strobe[9] = 1'b1;
         S_START:  w_strobe[8] = 1'b1;
         S_TARGET: w_strobe[7] = 1'b1;
         S_LOAD_A: w_strobe[6] = 1'b1;
         S_LOAD_S: w_strobe[5] = 1'b1;
         S_DRAW:   w_strobe[4] = 1'b1;
         S_HIT:    w_strobe[3] = 1'b1;
         S_MISS:   w_strobe[2] = 1'b1;
         S_WIN:    w_strobe[1] = 1'b1;
         S_LOSE:   w_strobe[0] = 1'b1;
         default:  w_strobe = '0;
      endcase
      if (w_hold) w_strobe = '0;
   end

   assign io_bus.datapath_reset         = w_strobe[9];
   assign io_bus.datapath_start         = w_strobe[8];
   assign io_bus.datapath_target        = w_strobe[7];
   assign io_bus.datapath_load_angle    = w_strobe[6];
   assign io_bus.datapath_load_strength = w_strobe[5];
   assign io_bus.datapath_draw          = w_strobe[4];
   assign io_bus.datapath_hit           = w_strobe[3];
   assign io_bus.datapath_miss          = w_strobe[2];
   assign io_bus.datapath_win           = w_strobe[1];
   assign io_bus.datapath_lose          = w_strobe[0];
   assign io_bus.shots_left             = r_shots_left;
   assign io_bus.score                  = r_score;
endmodule
